// File: rtl/alu_share_scheduler.sv
// Round-robin sharing of one combinational ALU between NREQ requesters.
// Each op runs IDLE (grant) -> EXEC (ALU driven from op regs) -> RESP (hold result).
module alu_share_scheduler #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [4*NREQ-1:0]     req_ctrl,
  input  logic [WIDTH*NREQ-1:0] req_a,
  input  logic [WIDTH*NREQ-1:0] req_b,
  output logic [3:0]            alu_ctrl,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic                  alu_zero,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_zero,
  output logic                  busy
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [3:0]        ctrl_q, ctrl_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              zero_q, zero_d;

  logic              found;
  logic [PW-1:0]     winner;
  logic [PW-1:0]     cand;
  int                arb_idx;

  // Scan from ptr downward in priority so the lowest offset wins last.
  always_comb begin
    found   = 1'b0;
    winner  = ptr_q;
    arb_idx = 0;
    cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      arb_idx = int'(ptr_q) + k;
      if (arb_idx >= NREQ) arb_idx = arb_idx - NREQ;
      cand = PW'(arb_idx);
      if (req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    ctrl_d    = ctrl_q;
    a_d       = a_q;
    b_d       = b_q;
    data_d    = data_q;
    zero_d    = zero_q;
    req_ready = '0;
    rsp_valid = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          req_ready[winner] = 1'b1;
          ctrl_d  = req_ctrl[4*winner +: 4];
          a_d     = req_a[WIDTH*winner +: WIDTH];
          b_d     = req_b[WIDTH*winner +: WIDTH];
          owner_d = winner;
          state_d = EXEC;
        end
      end
      EXEC: begin
        data_d  = alu_result;
        zero_d  = alu_zero;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid[owner_q] = 1'b1;
        if (rsp_ready[owner_q]) begin
          ptr_d   = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      ctrl_q  <= 4'b0010;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      ctrl_q  <= ctrl_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
    end
  end

  assign alu_ctrl = ctrl_q;
  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign rsp_data = data_q;
  assign rsp_zero = zero_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_scheduler.sv
// Directed bench for alu_share_scheduler with a behavioural ALU model.
module tb_alu_share_scheduler;
  localparam int W = 32;
  localparam int N = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [4*N-1:0] req_ctrl;
  logic [W*N-1:0] req_a;
  logic [W*N-1:0] req_b;
  logic [3:0]     alu_ctrl;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [W-1:0]   alu_result;
  logic           alu_zero;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic [W-1:0]   rsp_data;
  logic           rsp_zero;
  logic           busy;

  int errs = 0;
  int checks = 0;

  alu_share_scheduler #(.WIDTH(W), .NREQ(N)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ctrl(req_ctrl), .req_a(req_a), .req_b(req_b),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_ctrl)
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b1101: alu_result = alu_a - alu_b;
      4'b1011: alu_result = alu_b;
      default: alu_result = alu_a & alu_b;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, logic [3:0] c, logic [31:0] a, logic [31:0] b);
    req_ctrl[4*i +: 4] = c;
    req_a[W*i +: W]    = a;
    req_b[W*i +: W]    = b;
  endtask

  task automatic check_reset(string tag);
    check({tag, ".req_ready"}, 32'(req_ready), 32'h0);
    check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'h0);
    check({tag, ".busy"}, 32'(busy), 32'h0);
    check({tag, ".rsp_data"}, rsp_data, 32'h0);
    check({tag, ".rsp_zero"}, 32'(rsp_zero), 32'h0);
    check({tag, ".alu_ctrl"}, 32'(alu_ctrl), 32'h2);
    check({tag, ".alu_a"}, alu_a, 32'h0);
    check({tag, ".alu_b"}, alu_b, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    req_ctrl = '0;
    req_a = '0;
    req_b = '0;
    step();
    check_reset("por");
    reset = 1'b0;
    step();

    // single op
    set_req(0, 4'b0010, 32'd5, 32'd7);
    req_valid = 2'b01;
    #1 check("t1.grant", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    check("t1.ex_ctrl", 32'(alu_ctrl), 32'h2);
    check("t1.ex_a", alu_a, 32'd5);
    check("t1.ex_b", alu_b, 32'd7);
    check("t1.ex_busy", 32'(busy), 32'h1);
    check("t1.ex_rspv", 32'(rsp_valid), 32'h0);
    check("t1.ex_rdy", 32'(req_ready), 32'h0);
    step();
    check("t1.rspv", 32'(rsp_valid), 32'h1);
    check("t1.data", rsp_data, 32'd12);
    check("t1.zero", 32'(rsp_zero), 32'h0);
    rsp_ready = 2'b01;
    step();
    rsp_ready = '0;
    check("t1.idle_busy", 32'(busy), 32'h0);
    check("t1.idle_rspv", 32'(rsp_valid), 32'h0);

    // contention after reset
    reset = 1'b1;
    #1 reset = 1'b0;
    set_req(0, 4'b0010, 32'd1, 32'd1);
    set_req(1, 4'b0110, 32'd9, 32'd4);
    req_valid = 2'b11;
    #1 check("t2.first", 32'(req_ready), 32'h1);
    step();
    req_valid = 2'b10;
    check("t2.ex_rdy", 32'(req_ready), 32'h0);
    step();
    check("t2.rspv0", 32'(rsp_valid), 32'h1);
    check("t2.data0", rsp_data, 32'd2);
    rsp_ready = 2'b01;
    req_valid = 2'b11;
    step();
    rsp_ready = '0;
    check("t2.second", 32'(req_ready), 32'h2);
    step();
    req_valid = 2'b01;
    step();
    check("t2.rspv1", 32'(rsp_valid), 32'h2);
    check("t2.data1", rsp_data, 32'd5);
    rsp_ready = 2'b10;
    step();
    rsp_ready = '0;
    check("t2.third", 32'(req_ready), 32'h1);

    // backpressure
    set_req(0, 4'b1011, 32'd3, 32'h0000_abcd);
    step();
    req_valid = '0;
    step();
    req_valid = 2'b11;
    for (int i = 0; i < 10; i++) begin
      check("t3.rspv", 32'(rsp_valid), 32'h1);
      check("t3.data", rsp_data, 32'h0000_abcd);
      check("t3.busy", 32'(busy), 32'h1);
      check("t3.rdy", 32'(req_ready), 32'h0);
      step();
    end
    req_valid = '0;
    rsp_ready = 2'b01;
    step();
    rsp_ready = '0;
    check("t3.rel_busy", 32'(busy), 32'h0);
    check("t3.rel_rspv", 32'(rsp_valid), 32'h0);

    // idle gap, pointer parked at requester 1
    for (int i = 0; i < 5; i++) begin
      check("t6.busy", 32'(busy), 32'h0);
      check("t6.rdy", 32'(req_ready), 32'h0);
      step();
    end
    req_valid = 2'b11;
    #1 check("t6.ptr", 32'(req_ready), 32'h2);
    req_valid = '0;

    // branch compare to requester 1
    set_req(1, 4'b1101, 32'h8000_0000, 32'h8000_0000);
    req_valid = 2'b10;
    #1 check("t4.grant", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    step();
    check("t4.rspv", 32'(rsp_valid), 32'h2);
    check("t4.zero", 32'(rsp_zero), 32'h1);
    rsp_ready = 2'b01;
    step();
    rsp_ready = '0;
    check("t4.ign_rspv", 32'(rsp_valid), 32'h2);
    check("t4.ign_busy", 32'(busy), 32'h1);
    rsp_ready = 2'b10;
    step();
    rsp_ready = '0;
    check("t4.done", 32'(busy), 32'h0);

    // reset during EXEC
    set_req(1, 4'b0010, 32'd1, 32'd2);
    req_valid = 2'b10;
    #1 check("t5.grant", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    reset = 1'b1;
    #1 check_reset("t5.exec");
    reset = 1'b0;
    step();
    check("t5.e_rspv1", 32'(rsp_valid), 32'h0);
    step();
    check("t5.e_rspv2", 32'(rsp_valid), 32'h0);
    check("t5.e_busy", 32'(busy), 32'h0);

    // reset during RESP with pointer at requester 1
    set_req(0, 4'b0110, 32'd10, 32'd3);
    req_valid = 2'b01;
    step();
    req_valid = '0;
    step();
    check("t5.op0", rsp_data, 32'd7);
    rsp_ready = 2'b01;
    step();
    rsp_ready = '0;
    set_req(1, 4'b0010, 32'h10, 32'h20);
    req_valid = 2'b10;
    step();
    req_valid = '0;
    step();
    check("t5.r_rspv", 32'(rsp_valid), 32'h2);
    check("t5.r_data", rsp_data, 32'h30);
    reset = 1'b1;
    #1 check_reset("t5.resp");
    reset = 1'b0;
    step();
    check("t5.r_after", 32'(rsp_valid), 32'h0);
    req_valid = 2'b11;
    #1 check("t5.from0", 32'(req_ready), 32'h1);
    req_valid = '0;
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
